// File: rtl/store_check_pkg.sv
// Shared types and helpers for the store self-check monitor.
// The slot decoder lives here so the top and any wrapper agree on window geometry.
package store_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sc_state_t;

    localparam logic [7:0] SC_IDX_NONE = 8'hFF;

    typedef struct packed {
        logic        in_win;
        logic [31:0] idx;
    } sc_slot_t;

    // off is the byte offset from slot 0, already wrapped to XLEN and zero-extended
    function automatic sc_slot_t sc_slot(input logic [63:0] off,
                                         input int unsigned n_checks,
                                         input int unsigned stride_log2);
        sc_slot_t    s;
        logic [63:0] span;
        logic [63:0] mask;
        span     = 64'(n_checks) << stride_log2;
        mask     = (64'd1 << stride_log2) - 64'd1;
        s.in_win = (off < span) && ((off & mask) == 64'd0);
        s.idx    = 32'(off >> stride_log2);
        return s;
    endfunction

endpackage

// File: rtl/store_check_monitor_if.sv
// Bus bundle for the store self-check monitor: table load, start, snooped
// store port and verdict outputs.
interface store_check_monitor_if #(
    parameter int XLEN     = 32,
    parameter int N_CHECKS = 8,
    parameter int CNT_W    = 16
);
    localparam int IDX_W = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1;

    logic             exp_we;
    logic [IDX_W-1:0] exp_idx;
    logic [XLEN-1:0]  exp_data;
    logic             start;
    logic             memwrite;
    logic [XLEN-1:0]  dataadr;
    logic [XLEN-1:0]  writedata;

    logic             done;
    logic             pass;
    logic             timeout;
    logic [CNT_W-1:0] pass_count;
    logic [CNT_W-1:0] fail_count;
    logic [7:0]       first_fail_idx;
    logic [XLEN-1:0]  first_fail_data;

    modport master (
        output exp_we, exp_idx, exp_data, start, memwrite, dataadr, writedata,
        input  done, pass, timeout, pass_count, fail_count, first_fail_idx, first_fail_data
    );

    modport slave (
        input  exp_we, exp_idx, exp_data, start, memwrite, dataadr, writedata,
        output done, pass, timeout, pass_count, fail_count, first_fail_idx, first_fail_data
    );

endinterface

// File: rtl/store_check_exp_table.sv
// Expected-value register file: one synchronous write port, one async read port.
// No reset, so the table survives a monitor reset and can be reused on restart.
module store_check_exp_table #(
    parameter int XLEN     = 32,
    parameter int N_CHECKS = 8,
    parameter int IDX_W    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [XLEN-1:0]  wdata,
    input  logic [IDX_W-1:0] ridx,
    output logic [XLEN-1:0]  rdata
);

    logic [N_CHECKS-1:0][XLEN-1:0] mem;

    always_ff @(posedge clk) begin
        if (we && (32'(widx) < N_CHECKS)) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/store_check_monitor.sv
// Snoops core stores into a result window, scores them against the expected
// table, and produces a single done/pass verdict with a cycle timeout.
module store_check_monitor
    import store_check_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int N_CHECKS       = 8,
    parameter int BASE_ADDR      = 200,
    parameter int STRIDE         = 4,
    parameter int TIMEOUT_CYCLES = 300,
    parameter int ORDERED        = 0,
    parameter int CNT_W          = 16
) (
    input logic           clk,
    input logic           rst,
    store_check_monitor_if.slave bus
);

    localparam int IDX_W = (N_CHECKS > 1) ? $clog2(N_CHECKS) : 1;
    localparam int SLOG2 = (STRIDE > 1) ? $clog2(STRIDE) : 0;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [XLEN-1:0]  BASE    = XLEN'(BASE_ADDR);
    localparam logic [TW-1:0]    T_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] N_PASS  = CNT_W'(N_CHECKS);

    sc_state_t           state;
    logic [N_CHECKS-1:0] seen;
    logic [TW-1:0]       tcnt;
    logic                done_q;
    logic                timeout_q;
    logic [CNT_W-1:0]    pass_count_q;
    logic [CNT_W-1:0]    fail_count_q;
    logic [7:0]          ffi_q;
    logic [XLEN-1:0]     ffd_q;

    logic [XLEN-1:0]     off;
    sc_slot_t            slot;
    logic                win;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    next_idx;
    logic [XLEN-1:0]     exp_rd;
    logic                first_seen;
    logic                good;
    logic                bad;

    store_check_exp_table #(
        .XLEN     (XLEN),
        .N_CHECKS (N_CHECKS),
        .IDX_W    (IDX_W)
    ) u_tab (
        .clk   (clk),
        .we    (bus.exp_we && (state == IDLE)),
        .widx  (bus.exp_idx),
        .wdata (bus.exp_data),
        .ridx  (idx),
        .rdata (exp_rd)
    );

    // In ordered mode the next expected slot is the lowest one not yet written,
    // so a single out-of-order store does not cascade into later order errors.
    always_comb begin
        next_idx = '0;
        for (int i = N_CHECKS - 1; i >= 0; i--) begin
            if (!seen[i]) next_idx = IDX_W'(i);
        end
    end

    always_comb begin
        off        = bus.dataadr - BASE;
        slot       = sc_slot(64'(off), N_CHECKS, SLOG2);
        win        = slot.in_win && ((slot.idx >> IDX_W) == 32'd0);
        idx        = slot.idx[IDX_W-1:0];
        first_seen = 1'b0;
        good       = 1'b0;
        bad        = 1'b0;
        if (state == RUN && bus.memwrite) begin
            if (win && !seen[idx]) begin
                first_seen = 1'b1;
                if (ORDERED != 0 && idx != next_idx) bad = 1'b1;
                else if (exp_rd === bus.writedata)   good = 1'b1;
                else                                 bad = 1'b1;
            end else begin
                // duplicate, misaligned or outside the window
                bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            seen         <= '0;
            tcnt         <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            pass_count_q <= '0;
            fail_count_q <= '0;
            ffi_q        <= SC_IDX_NONE;
            ffd_q        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state        <= RUN;
                        seen         <= '0;
                        tcnt         <= '0;
                        pass_count_q <= '0;
                        fail_count_q <= '0;
                        ffi_q        <= SC_IDX_NONE;
                        ffd_q        <= '0;
                    end
                end
                RUN: begin
                    tcnt <= tcnt + 1'b1;
                    if (first_seen) seen[idx] <= 1'b1;
                    if (good && pass_count_q != CNT_MAX) pass_count_q <= pass_count_q + 1'b1;
                    if (bad) begin
                        if (fail_count_q != CNT_MAX) fail_count_q <= fail_count_q + 1'b1;
                        // fail_count only grows, so zero means no failure latched yet
                        if (fail_count_q == '0) begin
                            ffi_q <= win ? 8'(idx) : SC_IDX_NONE;
                            ffd_q <= bus.writedata;
                        end
                    end
                    // completion is checked first so it wins a tie with the timeout
                    if (&seen) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (tcnt == T_LAST) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.done            = done_q;
    assign bus.timeout         = timeout_q;
    assign bus.pass_count      = pass_count_q;
    assign bus.fail_count      = fail_count_q;
    assign bus.first_fail_idx  = ffi_q;
    assign bus.first_fail_data = ffd_q;
    assign bus.pass            = done_q && !timeout_q && (fail_count_q == '0) && (pass_count_q == N_PASS);

endmodule

// File: tb/tb_store_check_monitor.sv
// Scoreboard bench: an unordered and an ordered monitor see the same stimulus;
// a store-level reference model predicts each verdict, monitors compare on done.
module tb_store_check_monitor;
    import store_check_pkg::*;

    localparam int XLEN = 32, N = 8, CNT_W = 16, TMO = 300, BASE = 200, STRIDE = 4;

    typedef struct { logic [31:0] addr; logic [31:0] data; int at; } st_t;
    typedef struct {
        int done_edge; bit pass; bit tmo; int pc; int fc; logic [7:0] ffi; logic [31:0] ffd;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        exp_we, start, memwrite;
    logic [2:0]  exp_idx;
    logic [31:0] exp_data, dataadr, writedata;

    store_check_monitor_if #(.XLEN(XLEN), .N_CHECKS(N), .CNT_W(CNT_W)) bus0 ();
    store_check_monitor_if #(.XLEN(XLEN), .N_CHECKS(N), .CNT_W(CNT_W)) bus1 ();

    assign bus0.exp_we = exp_we;     assign bus1.exp_we = exp_we;
    assign bus0.exp_idx = exp_idx;   assign bus1.exp_idx = exp_idx;
    assign bus0.exp_data = exp_data; assign bus1.exp_data = exp_data;
    assign bus0.start = start;       assign bus1.start = start;
    assign bus0.memwrite = memwrite; assign bus1.memwrite = memwrite;
    assign bus0.dataadr = dataadr;   assign bus1.dataadr = dataadr;
    assign bus0.writedata = writedata; assign bus1.writedata = writedata;

    store_check_monitor #(.XLEN(XLEN), .N_CHECKS(N), .BASE_ADDR(BASE), .STRIDE(STRIDE),
        .TIMEOUT_CYCLES(TMO), .ORDERED(0), .CNT_W(CNT_W)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    store_check_monitor #(.XLEN(XLEN), .N_CHECKS(N), .BASE_ADDR(BASE), .STRIDE(STRIDE),
        .TIMEOUT_CYCLES(TMO), .ORDERED(1), .CNT_W(CNT_W)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] tab [N];
    st_t  plan[$];
    res_t q0[$], q1[$];
    int   last_at, last_s;
    int   dn_cyc0, dn_cyc1;
    bit   pd0, pd1;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    function automatic logic [31:0] A(input int i);
        return 32'(BASE + STRIDE * i);
    endfunction

    // Reference: walk the planned stores in time order, applying the scoring rules.
    function automatic res_t model(input int s, input bit ordered);
        res_t r;
        bit seen [N];
        int dedge, nseen, lu, i;
        logic [31:0] off, d;
        logic [7:0] fi;
        bit bad, good;
        foreach (seen[j]) seen[j] = 1'b0;
        r.pass = 0; r.tmo = 1; r.pc = 0; r.fc = 0; r.ffi = SC_IDX_NONE; r.ffd = 0;
        dedge = s + TMO; nseen = 0;
        for (int k = 0; k < plan.size(); k++) begin
            if (plan[k].at > dedge) break;
            off = plan[k].addr - 32'(BASE);
            d = plan[k].data;
            bad = 0; good = 0; fi = SC_IDX_NONE;
            if (off < 32'(N * STRIDE) && off % 32'(STRIDE) == 0) begin
                i = int'(off / 32'(STRIDE));
                fi = 8'(i);
                if (seen[i]) bad = 1;
                else begin
                    lu = 0;
                    while (seen[lu]) lu++;
                    seen[i] = 1; nseen++;
                    if (ordered && i != lu) bad = 1;
                    else if (d == tab[i]) good = 1;
                    else bad = 1;
                end
            end else bad = 1;
            if (good) r.pc++;
            if (bad) begin
                if (r.fc == 0) begin r.ffi = fi; r.ffd = d; end
                r.fc++;
            end
            if (nseen == N && r.tmo && plan[k].at + 1 <= s + TMO) begin
                dedge = plan[k].at + 1;
                r.tmo = 0;
            end
        end
        r.done_edge = dedge;
        r.pass = !r.tmo && r.fc == 0 && r.pc == N;
        return r;
    endfunction

    task automatic cmp_res(input string tg, input res_t e, input int dc, input bit p, input bit t,
                           input int pc, input int fc, input logic [7:0] fi, input logic [31:0] fd);
        chk({tg, ".done_cycle"}, dc, e.done_edge);
        chk({tg, ".pass"}, p, e.pass);
        chk({tg, ".timeout"}, t, e.tmo);
        chk({tg, ".pass_count"}, pc, e.pc);
        chk({tg, ".fail_count"}, fc, e.fc);
        chk({tg, ".first_fail_idx"}, fi, e.ffi);
        chk({tg, ".first_fail_data"}, fd, e.ffd);
    endtask

    always @(negedge clk) begin
        if (!rst && bus0.done && !pd0) begin
            dn_cyc0 <= cyc;
            if (q0.size() == 0) chk("sb0.unexpected_done", 1, 0);
            else cmp_res("sb0", q0.pop_front(), cyc, bus0.pass, bus0.timeout, int'(bus0.pass_count),
                         int'(bus0.fail_count), bus0.first_fail_idx, bus0.first_fail_data);
        end
        pd0 <= bus0.done;
    end

    always @(negedge clk) begin
        if (!rst && bus1.done && !pd1) begin
            dn_cyc1 <= cyc;
            if (q1.size() == 0) chk("sb1.unexpected_done", 1, 0);
            else cmp_res("sb1", q1.pop_front(), cyc, bus1.pass, bus1.timeout, int'(bus1.pass_count),
                         int'(bus1.fail_count), bus1.first_fail_idx, bus1.first_fail_data);
        end
        pd1 <= bus1.done;
    end

    task automatic plan_clear();
        plan.delete();
        last_at = 0;
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] d, input int gap);
        st_t e;
        e.addr = a; e.data = d; e.at = last_at + 1 + gap;
        last_at = e.at;
        plan.push_back(e);
    endtask

    task automatic rnd_we();
        exp_we   = ($urandom_range(0, 3) == 0);
        exp_idx  = 3'($urandom_range(0, N - 1));
        exp_data = $urandom;
    endtask

    task automatic do_reset();
        @(negedge clk);
        exp_we = 0; start = 0; memwrite = 0; rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    // Stray stores during the load must be ignored while idle.
    task automatic load_tab();
        for (int k = 0; k < N; k++) begin
            exp_we = 1; exp_idx = 3'(k); exp_data = tab[k];
            memwrite = 1; dataadr = A(k); writedata = ~tab[k];
            @(negedge clk);
        end
        exp_we = 0; memwrite = 0;
    endtask

    task automatic load_tp();
        for (int k = 0; k < 6; k++) tab[k] = 32'd1;
        tab[6] = 32'h12345000;
        tab[7] = 32'h00010078;
        load_tab();
    endtask

    task automatic run_plan();
        int s, lim;
        start = 1;
        s = cyc + 1;
        for (int k = 0; k < plan.size(); k++) plan[k].at += s;
        q0.push_back(model(s, 1'b0));
        q1.push_back(model(s, 1'b1));
        @(negedge clk);
        start = 0;
        for (int k = 0; k < plan.size(); k++) begin
            while (cyc + 1 < plan[k].at) begin
                memwrite = 0; rnd_we();
                @(negedge clk);
            end
            memwrite = 1; dataadr = plan[k].addr; writedata = plan[k].data; rnd_we();
            @(negedge clk);
        end
        memwrite = 0; exp_we = 0;
        lim = 0;
        while (!(bus0.done && bus1.done) && lim < TMO + 20) begin
            @(negedge clk);
            lim++;
        end
        chk("run.done_reached", bus0.done && bus1.done, 1);
        @(negedge clk);
        last_s = s;
    endtask

    task automatic chk_idle(input string tg);
        chk({tg, ".done"}, bus0.done, 0);
        chk({tg, ".pass"}, bus0.pass, 0);
        chk({tg, ".timeout"}, bus0.timeout, 0);
        chk({tg, ".pass_count"}, bus0.pass_count, 0);
        chk({tg, ".fail_count"}, bus0.fail_count, 0);
        chk({tg, ".first_fail_idx"}, bus0.first_fail_idx, 8'hFF);
        chk({tg, ".first_fail_data"}, bus0.first_fail_data, 0);
    endtask

    function automatic logic [31:0] junk_addr();
        case ($urandom_range(0, 2))
            0:       return A(N + int'($urandom_range(0, 7)));
            1:       return 32'(BASE) - 32'(4 * $urandom_range(1, 4));
            default: return A(int'($urandom_range(0, N - 1))) + 32'($urandom_range(1, 3));
        endcase
    endfunction

    task automatic gen_random();
        int sl [N];
        int t, j;
        logic [31:0] d;
        for (int k = 0; k < N; k++) sl[k] = k;
        if ($urandom_range(0, 1) == 1) begin
            for (int k = N - 1; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                t = sl[k]; sl[k] = sl[j]; sl[j] = t;
            end
        end
        plan_clear();
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 7) == 0) add(junk_addr(), $urandom, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 19) == 0) continue;
            d = tab[sl[k]];
            if ($urandom_range(0, 7) == 0) d = d ^ (32'd1 << $urandom_range(0, 31));
            add(A(sl[k]), d, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 11) == 0) add(A(sl[k]), d, 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_we = 0; exp_idx = 0; exp_data = 0; start = 0;
        memwrite = 0; dataadr = 0; writedata = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        chk_idle("reset");

        // all eight correct, in order
        load_tp();
        plan_clear();
        for (int k = 0; k < N; k++) add(A(k), tab[k], 0);
        run_plan();
        chk("t1.pass", bus0.pass, 1);
        chk("t1.pass_count", bus0.pass_count, 8);
        chk("t1.fail_count", bus0.fail_count, 0);
        chk("t1.latency", dn_cyc0, last_s + 8 + 1);
        // DONE is frozen against stores, start and table writes
        repeat (3) begin
            memwrite = 1; dataadr = A(0); writedata = 32'hDEAD; start = 1;
            exp_we = 1; exp_idx = 0; exp_data = 0;
            @(negedge clk);
        end
        memwrite = 0; start = 0; exp_we = 0;
        @(negedge clk);
        chk("t1.frozen_done", bus0.done, 1);
        chk("t1.frozen_pass_count", bus0.pass_count, 8);
        chk("t1.frozen_fail_count", bus0.fail_count, 0);
        do_reset();

        // slot 6 mismatch
        load_tp();
        plan_clear();
        for (int k = 0; k < N; k++) add(A(k), (k == 6) ? 32'h12345001 : tab[k], 0);
        run_plan();
        chk("t2.pass", bus0.pass, 0);
        chk("t2.fail_count", bus0.fail_count, 1);
        chk("t2.first_fail_idx", bus0.first_fail_idx, 6);
        chk("t2.first_fail_data", bus0.first_fail_data, 32'h12345001);
        do_reset();

        // out-of-window store first
        load_tp();
        plan_clear();
        add(32'd232, 32'd1, 0);
        for (int k = 0; k < N; k++) add(A(k), tab[k], 0);
        run_plan();
        chk("t3.fail_count", bus0.fail_count, 1);
        chk("t3.first_fail_idx", bus0.first_fail_idx, 8'hFF);
        chk("t3.pass", bus0.pass, 0);
        do_reset();

        // duplicate write of 204
        load_tp();
        plan_clear();
        add(A(0), tab[0], 0);
        add(A(1), tab[1], 0);
        add(A(1), tab[1], 0);
        for (int k = 2; k < N; k++) add(A(k), tab[k], 0);
        run_plan();
        chk("t4.fail_count", bus0.fail_count, 1);
        chk("t4.pass_count", bus0.pass_count, 8);
        do_reset();

        // 208 before 204: order error only on the ordered instance
        load_tp();
        plan_clear();
        add(A(0), tab[0], 0);
        add(A(2), tab[2], 0);
        add(A(1), tab[1], 0);
        for (int k = 3; k < N; k++) add(A(k), tab[k], 0);
        run_plan();
        chk("t5.unordered_pass", bus0.pass, 1);
        chk("t5.ordered_pass", bus1.pass, 0);
        chk("t5.ordered_first_fail_idx", bus1.first_fail_idx, 2);
        do_reset();

        // seven slots only: timeout
        load_tp();
        plan_clear();
        for (int k = 0; k < N - 1; k++) add(A(k), tab[k], 0);
        run_plan();
        chk("t6.done", bus0.done, 1);
        chk("t6.timeout", bus0.timeout, 1);
        chk("t6.pass", bus0.pass, 0);
        chk("t6.done_cycle", dn_cyc0, last_s + TMO);
        do_reset();

        // reset mid-RUN, then restart on the retained table
        load_tp();
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 4; k++) begin
            memwrite = 1; dataadr = A(k); writedata = (k == 2) ? 32'h5 : tab[k];
            @(negedge clk);
        end
        memwrite = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk_idle("t7.midrun_reset");
        plan_clear();
        for (int k = 0; k < N; k++) add(A(k), tab[k], int'($urandom_range(0, 1)));
        run_plan();
        chk("t7.restart_pass", bus0.pass, 1);
        chk("t7.restart_pass_ordered", bus1.pass, 1);
        do_reset();

        // randomized scenarios
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < N; k++) tab[k] = $urandom;
            load_tab();
            gen_random();
            run_plan();
            do_reset();
        end

        repeat (3) @(negedge clk);
        chk("sb0.pending", q0.size(), 0);
        chk("sb1.pending", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_check_monitor.md
# store_check_monitor

Synthesizable, parametrised self-check monitor for the pipelined RV32I core. It snoops the core's data-memory write port (`memwrite`/`dataadr`/`writedata`) and compares each store into a fixed result window against a runtime-loaded table of expected values. It counts passes and failures, detects duplicate, unexpected and out-of-order stores, and applies a cycle-count timeout. It replaces per-test hard-coded address `case` checkers, can be instantiated in any directed test bench or FPGA wrapper, and ends with a single `done`/`pass` verdict.

## Interface
- `XLEN`, 32: data/address width.
- `N_CHECKS`, 8: number of result slots in the window (≥1).
- `BASE_ADDR`, 200: byte address of slot 0.
- `STRIDE`, 4: byte distance between slots (power of two).
- `TIMEOUT_CYCLES`, 300: RUN cycles before forced finish.
- `ORDERED`, 0: 1 = slots must be written in index order.
- `CNT_W`, 16: width of pass/fail counters.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `exp_we` in 1: write expected-table entry (honoured in IDLE only).
- `exp_idx` in $clog2(N_CHECKS): entry index.
- `exp_data` in XLEN: expected value.
- `start` in 1: IDLE→RUN pulse.
- `memwrite` in 1: core store strobe.
- `dataadr` in XLEN: store byte address.
- `writedata` in XLEN: store data.
- `done` out 1: verdict valid (level, held in DONE).
- `pass` out 1: all slots written once, all matched, no errors, no timeout.
- `timeout` out 1: finish caused by timeout.
- `pass_count` out CNT_W: matching first writes.
- `fail_count` out CNT_W: mismatches + duplicates + unexpected + order errors.
- `first_fail_idx` out 8: slot of first failure, 8'hFF if out-of-window.
- `first_fail_data` out XLEN: `writedata` of first failure.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE; all outputs 0, `first_fail_idx` = 8'hFF, seen-bitmap cleared, timeout counter 0, expected table contents unchanged.
- IDLE: `exp_we` writes the table; `memwrite` is ignored; `start` → RUN and clears the counters, bitmap and first-fail registers.
- RUN, on each `memwrite`, compute `off = dataadr - BASE_ADDR` modulo 2^XLEN:
  - In window (`off` < N_CHECKS*STRIDE and `off` % STRIDE == 0), with `idx = off/STRIDE`:
    - Slot not yet seen: set the seen bit.
    - ORDERED=1 and `idx` ≠ next-expected index: order error → fail.
    - Otherwise compare with `exp[idx]`, full XLEN, case-equality semantics: equal → pass++, else fail++.
    - Slot already seen: duplicate → fail++; bitmap unchanged.
  - Out of window or misaligned: unexpected → fail++, `first_fail_idx` = 8'hFF.
- `exp_we` in RUN/DONE is ignored. `start` in RUN/DONE is ignored.
- First failure only latches `first_fail_idx`/`first_fail_data`.
- Counters saturate at 2^CNT_W−1.
- RUN → DONE when all N_CHECKS seen bits are set, or when the timeout counter reaches TIMEOUT_CYCLES−1 (then `timeout` = 1).
- If both conditions hold in the same cycle, completion wins: `timeout` = 0.
- DONE: outputs frozen; `memwrite` ignored; leave DONE only via `rst`.
- `pass` = `done` & ~`timeout` & (`fail_count` == 0) & (`pass_count` == N_CHECKS).

## Timing
- Store sampled at rising edge N. Counters, bitmap and first-fail registers are visible after edge N (registered, latency 1).
- `done` rises at the edge after the one that set the final seen bit (latency 2 from the store).
- Timeout counter increments every RUN cycle, starting with the first RUN cycle (counter value 0 in cycle 1).
- Table write: `exp[idx]` is readable for a store in the cycle after `exp_we`.
- `rst` mid-RUN: next cycle in IDLE with cleared status; table retained.
- Back-to-back stores every cycle are supported. One check per cycle; no stall output.

## Structure
- Package `store_check_pkg`: state enum `sc_state_t` {IDLE, RUN, DONE}, constant `SC_IDX_NONE` = 8'hFF, and a function computing the slot index and in-window flag.
- Sub-module `store_check_exp_table`: N_CHECKS×XLEN register file, 1 write port and 1 asynchronous read port.
- Top module contains the FSM, seen bitmap, counters and timeout.

## Test plan
- Load exp = {1,1,1,1,1,1,32'h12345000,32'h00010078}, start, store slots at 200..228 in order → `done` two cycles after the 228 store, `pass` = 1, `pass_count` = 8, `fail_count` = 0.
- Same stimulus, but the store to 224 carries 32'h12345001 → `pass` = 0, `fail_count` = 1, `first_fail_idx` = 6, `first_fail_data` = 32'h12345001.
- Store to address 232, then all eight correct stores → `fail_count` = 1, `first_fail_idx` = 8'hFF, `pass` = 0.
- Write 204 twice (both correct), then the rest → `fail_count` = 1 (duplicate), `pass_count` = 8.
- ORDERED=1: write 208 before 204 → order error, `first_fail_idx` = 2. ORDERED=0 with the same stimulus → `pass` = 1.
- Only 7 slots written with TIMEOUT_CYCLES=300 → `done` = 1 and `timeout` = 1 in RUN cycle 300, `pass` = 0. Also assert `rst` mid-RUN → all outputs 0 next cycle, and a restart passes with the retained table.
